// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC register, IF/ID pipeline register
// and a BOOT/RUN/HALT controller that stops fetching on an address fault.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    output logic        o_if_valid,
    output logic        o_halt
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);
    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, if_pc_nx, if_instr_nx;
    logic        if_valid_nx, fault, bubble;
    assign o_imem_addr = {2'b00, pc[31:2]};
    assign o_halt      = state == HALT;
    // A taken redirect supersedes the out-of-range check on the current pc.
    assign fault = i_redirect ? (i_redirect_pc[1:0] != 2'b00) : ({2'b00, pc[31:2]} >= DEPTH);
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        if_pc_nx    = o_if_pc;
        if_instr_nx = o_if_instr;
        if_valid_nx = o_if_valid;
        bubble      = 1'b0;
        case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (fault) begin
                    state_nx = HALT;
                    bubble   = 1'b1;
                end else if (i_redirect) begin
                    pc_nx  = i_redirect_pc;
                    bubble = 1'b1;
                end else if (i_flush) begin
                    pc_nx  = i_stall ? pc : pc + 32'd4;
                    bubble = 1'b1;
                end else if (!i_stall) begin
                    if_pc_nx    = pc;
                    if_instr_nx = i_imem_data;
                    if_valid_nx = 1'b1;
                    pc_nx       = pc + 32'd4;
                end
            end
            default: ;
        endcase
        if (bubble) begin
            if_pc_nx    = 32'd0;
            if_instr_nx = NOP_INSTR;
            if_valid_nx = 1'b0;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= BOOT;
        else       state <= state_nx;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc         <= RESET_PC;
            o_if_pc    <= 32'd0;
            o_if_instr <= NOP_INSTR;
            o_if_valid <= 1'b0;
        end else begin
            pc         <= pc_nx;
            o_if_pc    <= if_pc_nx;
            o_if_instr <= if_instr_nx;
            o_if_valid <= if_valid_nx;
        end
    end
endmodule
